// File: rtl/sum_n_ctrl.sv
// Sequential summation controller: captures a term count n, then accumulates
// n handshaked unsigned terms into a widened sum and pulses done when finished.
module sum_n_ctrl #(
    parameter int DW = 8,
    parameter int CW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CW-1:0]    n,
    input  logic             din_valid,
    input  logic [DW-1:0]    din,
    output logic             din_ready,
    output logic [CW-1:0]    cnt,
    output logic [DW+CW-1:0] sum,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_ACC  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]       state_reg, state_next;
    logic [CW-1:0]    n_reg, n_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [DW+CW-1:0] sum_reg, sum_next;
    logic [DW+CW-1:0] din_ext;
    logic             accept;

    // Zero-extend the term to the accumulator width.
    genvar gi;
    generate
        for (gi = 0; gi < DW + CW; gi++) begin : g_ext
            if (gi < DW) begin : g_data
                assign din_ext[gi] = din[gi];
            end else begin : g_zero
                assign din_ext[gi] = 1'b0;
            end
        end
    endgenerate

    // The cnt guard keeps the down-counter from ever wrapping below zero.
    assign accept = din_valid && (state_reg == ST_ACC) && (cnt_reg != '0);

    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        cnt_next   = cnt_reg;
        sum_next   = sum_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    n_next = n;
                    if (n != '0) begin
                        state_next = ST_LOAD;
                    end else begin
                        state_next = ST_DONE;
                        sum_next   = '0;
                        cnt_next   = '0;
                    end
                end
            end
            ST_LOAD: begin
                cnt_next   = n_reg;
                sum_next   = '0;
                state_next = ST_ACC;
            end
            ST_ACC: begin
                if (accept) begin
                    sum_next = sum_reg + din_ext;
                    cnt_next = cnt_reg - CW'(1);
                    if (cnt_reg == CW'(1)) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            n_reg     <= '0;
            cnt_reg   <= '0;
            sum_reg   <= '0;
        end else begin
            state_reg <= state_next;
            n_reg     <= n_next;
            cnt_reg   <= cnt_next;
            sum_reg   <= sum_next;
        end
    end

    assign din_ready = (state_reg == ST_ACC);
    assign busy      = (state_reg == ST_LOAD) || (state_reg == ST_ACC);
    assign done      = (state_reg == ST_DONE);
    assign cnt       = cnt_reg;
    assign sum       = sum_reg;

endmodule

// File: tb/tb_sum_n_ctrl.sv
// Directed bench for sum_n_ctrl: latency, stalls, max-value sum, n==0,
// mid-operation reset and ignored start requests.
module tb_sum_n_ctrl;

    localparam int DW = 8;
    localparam int CW = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CW-1:0]    n;
    logic             din_valid;
    logic [DW-1:0]    din;
    logic             din_ready;
    logic [CW-1:0]    cnt;
    logic [DW+CW-1:0] sum;
    logic             busy;
    logic             done;

    int tests = 0;
    int fails = 0;

    sum_n_ctrl #(.DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n         (n),
        .din_valid (din_valid),
        .din       (din),
        .din_ready (din_ready),
        .cnt       (cnt),
        .sum       (sum),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t1_din [4];
        int t2_din [5];
        int t2_vld [5];
        int t2_cnt [5];
        int cyc;
        logic seen_done;

        t1_din = '{3, 5, 7, 9};
        t2_din = '{10, 99, 20, 99, 30};
        t2_vld = '{1, 0, 1, 0, 1};
        t2_cnt = '{3, 2, 2, 1, 1};

        rst_n = 1'b0; start = 1'b0; n = '0; din_valid = 1'b0; din = '0;
        tick; tick;
        check("rst_cnt",   32'(cnt), 0);
        check("rst_sum",   32'(sum), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_done",  32'(done), 0);
        check("rst_ready", 32'(din_ready), 0);
        rst_n = 1'b1;
        tick;

        // n=4, din held valid; n changed after capture must be ignored
        start = 1'b1; n = 4'd4; din_valid = 1'b1; din = 8'd0;
        tick;
        start = 1'b0; n = 4'd9;
        check("t1_load_busy",  32'(busy), 1);
        check("t1_load_ready", 32'(din_ready), 0);
        tick;
        for (int i = 0; i < 4; i++) begin
            check("t1_acc_cnt",   32'(cnt), 32'(4 - i));
            check("t1_acc_ready", 32'(din_ready), 1);
            din = 8'(t1_din[i]);
            tick;
        end
        check("t1_done",  32'(done), 1);
        check("t1_sum",   32'(sum), 24);
        check("t1_cnt",   32'(cnt), 0);
        check("t1_ready", 32'(din_ready), 0);
        tick;
        din_valid = 1'b0;
        check("t1_done_pulse", 32'(done), 0);
        check("t1_sum_hold",   32'(sum), 24);
        $display("[TB] n=4 sum=%0d", sum);

        // n=3 with stalled cycles
        start = 1'b1; n = 4'd3;
        tick;
        start = 1'b0;
        tick;
        for (int i = 0; i < 5; i++) begin
            check("t2_cnt", 32'(cnt), 32'(t2_cnt[i]));
            din_valid = t2_vld[i][0];
            din = 8'(t2_din[i]);
            tick;
        end
        din_valid = 1'b0;
        check("t2_done", 32'(done), 1);
        check("t2_sum",  32'(sum), 60);
        check("t2_cnt0", 32'(cnt), 0);
        tick;
        $display("[TB] n=3 stalled sum=%0d", sum);

        // n=15 of 255: largest sum, done latency
        start = 1'b1; n = 4'd15; din_valid = 1'b1; din = 8'd255;
        tick;
        cyc = 1;
        start = 1'b0;
        while (!done && cyc < 40) begin
            tick;
            cyc++;
        end
        check("t3_latency", 32'(cyc), 17);
        check("t3_done",    32'(done), 1);
        check("t3_sum",     32'(sum), 3825);
        din_valid = 1'b0;
        tick;
        $display("[TB] n=15 sum=%0d cycles=%0d", sum, cyc);

        // n=0: immediate done, sum cleared
        start = 1'b1; n = 4'd0; din_valid = 1'b1; din = 8'd50;
        tick;
        start = 1'b0;
        check("t4_done",  32'(done), 1);
        check("t4_sum",   32'(sum), 0);
        check("t4_cnt",   32'(cnt), 0);
        check("t4_busy",  32'(busy), 0);
        check("t4_ready", 32'(din_ready), 0);
        tick;
        check("t4_done_pulse", 32'(done), 0);
        check("t4_sum_hold",   32'(sum), 0);
        check("t4_busy_after", 32'(busy), 0);
        din_valid = 1'b0;
        $display("[TB] n=0 sum=%0d", sum);

        // reset after two accepts, then fresh n=2
        start = 1'b1; n = 4'd5; din_valid = 1'b1; din = 8'd4;
        tick;
        start = 1'b0;
        tick;
        tick;
        check("t5_sum1", 32'(sum), 4);
        check("t5_cnt1", 32'(cnt), 4);
        tick;
        check("t5_sum2", 32'(sum), 8);
        check("t5_cnt2", 32'(cnt), 3);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("t5_rst_cnt",   32'(cnt), 0);
        check("t5_rst_sum",   32'(sum), 0);
        check("t5_rst_busy",  32'(busy), 0);
        check("t5_rst_ready", 32'(din_ready), 0);
        check("t5_rst_done",  32'(done), 0);
        seen_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (done) seen_done = 1'b1;
        end
        check("t5_no_done", 32'(seen_done), 0);
        start = 1'b1; n = 4'd2; din = 8'd1;
        tick;
        start = 1'b0;
        tick; tick; tick;
        check("t5_new_done", 32'(done), 1);
        check("t5_new_sum",  32'(sum), 2);
        din_valid = 1'b0;
        tick;
        $display("[TB] post-reset n=2 sum=%0d", sum);

        // start during ACC and during DONE must be ignored
        start = 1'b1; n = 4'd2; din_valid = 1'b1; din = 8'd10;
        tick;
        start = 1'b0;
        tick;
        start = 1'b1; n = 4'd7;
        tick;
        start = 1'b0; din = 8'd20;
        check("t6_acc_cnt", 32'(cnt), 1);
        tick;
        check("t6_done", 32'(done), 1);
        check("t6_sum",  32'(sum), 30);
        start = 1'b1; n = 4'd3;
        tick;
        start = 1'b0;
        check("t6_idle_done", 32'(done), 0);
        check("t6_idle_busy", 32'(busy), 0);
        check("t6_idle_sum",  32'(sum), 30);
        check("t6_idle_cnt",  32'(cnt), 0);
        tick;
        check("t6_still_busy", 32'(busy), 0);
        check("t6_still_done", 32'(done), 0);
        check("t6_still_sum",  32'(sum), 30);
        din_valid = 1'b0;
        $display("[TB] ignored-start n=2 sum=%0d", sum);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
